// File: rtl/msx_mouse_port_if.sv
// Bus between the PS/2 source / MSX joystick pins and the mouse port.
interface msx_mouse_port_if;
    logic [24:0] ps2_mouse;
    logic        strobe;
    logic [5:0]  data;
    logic        active;

    modport master (output ps2_mouse, output strobe, input data, input active);
    modport slave  (input ps2_mouse, input strobe, output data, output active);
endinterface

// File: rtl/msx_mouse_port.sv
// Converts MiSTer PS/2 mouse packets into the MSX strobe-driven 4-nibble mouse protocol.
// Motion accumulates between reads, is snapshotted on the first strobe edge and served as nibbles.
module msx_mouse_port #(
    parameter int unsigned CLK_HZ     = 21477270,
    parameter int unsigned TIMEOUT_US = 1500
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    msx_mouse_port_if.slave bus
);
    localparam int unsigned TO_CYCLES =
        32'((64'(CLK_HZ) * 64'(TIMEOUT_US) + 64'd500000) / 64'd1000000);
    localparam int unsigned TO_MAX = TO_CYCLES - 1;
    localparam int unsigned CNT_W  = $clog2(TO_CYCLES);

    typedef enum logic [2:0] {ST_IDLE, ST_XH, ST_XL, ST_YH, ST_YL} state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync2_q, strb_prev_q;
    logic               pkt_old_q, primed_q;
    logic [9:0]         acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [7:0]         snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         data_q, data_d;
    logic               active_q, active_d;
    logic [1:0]         btn_d;
    logic [3:0]         nib_c;
    logic [8:0]         dx_c, dy_c;
    logic               strb_edge_c, timeout_c, pkt_c, snap_c;
    logic               unused_c;

    assign unused_c = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:2]};

    function automatic logic [9:0] sat10(input logic signed [11:0] v);
        if (v > 12'sd511)  return 10'h1FF;
        if (v < -12'sd512) return 10'h200;
        return v[9:0];
    endfunction

    function automatic logic [7:0] sat8(input logic signed [9:0] v);
        if (v > 10'sd127)  return 8'h7F;
        if (v < -10'sd128) return 8'h80;
        return v[7:0];
    endfunction

    // Next-state: sequencing, accumulation, snapshot and output nibble
    always_comb begin
        strb_edge_c = sync2_q ^ strb_prev_q;
        timeout_c   = (cnt_q == CNT_W'(TO_MAX));
        pkt_c       = primed_q && (bus.ps2_mouse[24] != pkt_old_q);
        dx_c        = {bus.ps2_mouse[4], bus.ps2_mouse[15:8]};
        dy_c        = {bus.ps2_mouse[5], bus.ps2_mouse[23:16]};
        snap_c      = strb_edge_c && (state_q == ST_IDLE || state_q == ST_YL);

        state_d  = state_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        snap_x_d = snap_x_q;
        snap_y_d = snap_y_q;
        btn_d    = data_q[5:4];
        nib_c    = 4'h0;

        case (state_q)
            ST_IDLE: if (strb_edge_c) state_d = ST_XH;
            ST_XH:   if (strb_edge_c) state_d = ST_XL;
            ST_XL:   if (strb_edge_c) state_d = ST_YH;
            ST_YH:   if (strb_edge_c) state_d = ST_YL;
            ST_YL:   if (strb_edge_c) state_d = ST_XH;
            default: state_d = ST_IDLE;
        endcase
        if (!strb_edge_c && timeout_c) state_d = ST_IDLE;

        // Snapshot takes the pre-packet totals; a coincident packet lands in the cleared accumulator
        if (snap_c) begin
            snap_x_d = sat8(acc_x_q);
            snap_y_d = sat8(acc_y_q);
            acc_x_d  = 10'h000;
            acc_y_d  = 10'h000;
        end
        if (pkt_c) begin
            acc_x_d = sat10({{2{acc_x_d[9]}}, acc_x_d} - {{3{dx_c[8]}}, dx_c});
            acc_y_d = sat10({{2{acc_y_d[9]}}, acc_y_d} + {{3{dy_c[8]}}, dy_c});
            btn_d   = {~bus.ps2_mouse[1], ~bus.ps2_mouse[0]};
        end

        case (state_d)
            ST_XH:   nib_c = snap_x_d[7:4];
            ST_XL:   nib_c = snap_x_d[3:0];
            ST_YH:   nib_c = snap_y_d[7:4];
            ST_YL:   nib_c = snap_y_d[3:0];
            default: nib_c = 4'h0;
        endcase

        data_d   = {btn_d, nib_c};
        active_d = pkt_c;
        cnt_d    = strb_edge_c ? '0 : (timeout_c ? cnt_q : cnt_q + CNT_W'(1));
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            strb_prev_q <= 1'b0;
            pkt_old_q   <= 1'b0;
            primed_q    <= 1'b0;
            state_q     <= ST_IDLE;
            acc_x_q     <= 10'h000;
            acc_y_q     <= 10'h000;
            snap_x_q    <= 8'h00;
            snap_y_q    <= 8'h00;
            cnt_q       <= '0;
            data_q      <= 6'b110000;
            active_q    <= 1'b0;
        end else begin
            sync1_q     <= bus.strobe;
            sync2_q     <= sync1_q;
            strb_prev_q <= sync2_q;
            pkt_old_q   <= bus.ps2_mouse[24];
            primed_q    <= 1'b1;
            state_q     <= state_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            active_q    <= active_d;
        end
    end

    assign bus.data   = data_q;
    assign bus.active = active_q;
endmodule
